// File: rtl/frame_capture_writer.sv
// Captures one visible frame of {red, green, blue} pixels into a linear frame-buffer write stream.
// Every output is registered, so it shows the decision taken on the previous pixel.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  S_IDLE    | no capture pending; waits for capture_req
//  S_ARMED   | request accepted; waits for the first visible pixel of a frame
//  S_CAPTURE | writing visible pixels; aborts on a counter discontinuity
//  S_DONE    | one-cycle completion; re-arms when continuous or capture_req is set
module frame_capture_writer #(
    parameter int H_ACTIVE_START = 144,
    parameter int H_ACTIVE_END   = 783,
    parameter int V_ACTIVE_START = 35,
    parameter int V_ACTIVE_END   = 514,
    parameter int H_TOTAL        = 800,
    parameter int V_TOTAL        = 525,
    parameter int ADDR_W         = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       h_count_value,
    input  logic [15:0]       v_count_value,
    input  logic [3:0]        red,
    input  logic [3:0]        green,
    input  logic [3:0]        blue,
    input  logic              capture_req,
    input  logic              continuous,
    output logic [ADDR_W-1:0] address_write,
    output logic [11:0]       data_write,
    output logic              write_en,
    output logic              busy,
    output logic              frame_done,
    output logic              capture_error
);
    localparam int FRAME_PIXELS = (H_ACTIVE_END - H_ACTIVE_START + 1) *
                                  (V_ACTIVE_END - V_ACTIVE_START + 1);
    localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [15:0] HS = 16'(H_ACTIVE_START);
    localparam logic [15:0] HE = 16'(H_ACTIVE_END);
    localparam logic [15:0] VS = 16'(V_ACTIVE_START);
    localparam logic [15:0] VE = 16'(V_ACTIVE_END);
    localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t            state;
    logic [15:0]       prev_h;
    logic [15:0]       prev_v;
    logic [ADDR_W-1:0] pix_idx;

    logic [15:0]       exp_h;
    logic [15:0]       exp_v;
    logic              cont_ok;
    logic              active;
    logic              first_px;
    logic              last_px;
    logic [ADDR_W-1:0] next_idx;
    logic [11:0]       pixel;

    always_comb begin
        exp_h = prev_h + 16'd1;
        exp_v = prev_v;
        if (prev_h == H_LAST) begin
            exp_h = 16'd0;
            exp_v = (prev_v == V_LAST) ? 16'd0 : prev_v + 16'd1;
        end
    end

    assign cont_ok  = (h_count_value == exp_h) && (v_count_value == exp_v);
    assign active   = (h_count_value >= HS) && (h_count_value <= HE) &&
                      (v_count_value >= VS) && (v_count_value <= VE);
    assign first_px = (h_count_value == HS) && (v_count_value == VS);
    assign last_px  = (h_count_value == HE) && (v_count_value == VE);
    // The index wraps instead of running past the last visible pixel.
    assign next_idx = (pix_idx == LAST_INDEX) ? '0 : pix_idx + 1'b1;
    assign pixel    = {red, green, blue};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            prev_h        <= '0;
            prev_v        <= '0;
            pix_idx       <= '0;
            address_write <= '0;
            data_write    <= '0;
            write_en      <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            capture_error <= 1'b0;
        end else begin
            prev_h        <= h_count_value;
            prev_v        <= v_count_value;
            write_en      <= 1'b0;
            frame_done    <= 1'b0;
            capture_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (capture_req) state <= S_ARMED;
                end
                S_ARMED: begin
                    busy <= 1'b1;
                    if (first_px) begin
                        write_en      <= 1'b1;
                        address_write <= pix_idx;
                        data_write    <= pixel;
                        pix_idx       <= next_idx;
                        state         <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    // A broken counter sequence means the frame is corrupt: drop it.
                    if (!cont_ok) begin
                        capture_error <= 1'b1;
                        busy          <= 1'b0;
                        pix_idx       <= '0;
                        state         <= S_IDLE;
                    end else begin
                        busy <= 1'b1;
                        if (active) begin
                            write_en      <= 1'b1;
                            address_write <= pix_idx;
                            data_write    <= pixel;
                            pix_idx       <= next_idx;
                            if (last_px) state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    pix_idx    <= '0;
                    state      <= (continuous || capture_req) ? S_ARMED : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_capture_writer.sv
// Bench for frame_capture_writer on a shrunken raster: directed scenarios plus a random soak,
// each cycle compared against a position-arithmetic reference model.
module tb_frame_capture_writer;
    localparam int HT  = 20;
    localparam int VT  = 12;
    localparam int HS  = 4;
    localparam int HE  = 13;
    localparam int VS  = 2;
    localparam int VE  = 9;
    localparam int W   = HE - HS + 1;
    localparam int NPX = W * (VE - VS + 1);
    localparam int TOT = HT * VT;

    logic        clk;
    logic        rst_in;
    logic [15:0] h_in, v_in;
    logic [3:0]  r_in, g_in, b_in;
    logic        req_in, cont_in;
    logic [18:0] address_write;
    logic [11:0] data_write;
    logic        write_en, busy, frame_done, capture_error;

    frame_capture_writer #(
        .H_ACTIVE_START(HS), .H_ACTIVE_END(HE),
        .V_ACTIVE_START(VS), .V_ACTIVE_END(VE),
        .H_TOTAL(HT), .V_TOTAL(VT), .ADDR_W(19)
    ) dut (
        .clk(clk), .rst_n(rst_in),
        .h_count_value(h_in), .v_count_value(v_in),
        .red(r_in), .green(g_in), .blue(b_in),
        .capture_req(req_in), .continuous(cont_in),
        .address_write(address_write), .data_write(data_write),
        .write_en(write_en), .busy(busy),
        .frame_done(frame_done), .capture_error(capture_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // raster driver state
    int pos = 0;
    int glitch_pos = -1;
    int glitch_rate = 0;
    bit fix_col = 0;

    // reference model: idle / waiting for frame start / capturing / completion pending
    int   m_mode = 0;
    int   m_prev = 0;
    bit   e_we, e_busy, e_fd, e_err;
    int   e_addr;
    logic [11:0] e_data;

    // scenario monitors
    int nwr, nfd, nerr, first_addr, last_addr;
    bit got_first;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update();
        int  cur;
        bit  act, ok;
        cur = int'(v_in) * HT + int'(h_in);
        act = (h_in >= HS) && (h_in <= HE) && (v_in >= VS) && (v_in <= VE);
        ok  = (cur == (m_prev + 1) % TOT);
        if (!rst_in) begin
            m_mode = 0; m_prev = 0;
            e_we = 0; e_busy = 0; e_fd = 0; e_err = 0; e_addr = 0; e_data = '0;
        end else begin
            e_we = 0; e_fd = 0; e_err = 0;
            if (m_mode == 0) begin
                e_busy = 0;
                if (req_in) m_mode = 1;
            end else if (m_mode == 1) begin
                e_busy = 1;
                if (h_in == HS && v_in == VS) begin
                    e_we = 1; e_addr = 0; e_data = {r_in, g_in, b_in};
                    m_mode = 2;
                end
            end else if (m_mode == 2) begin
                if (!ok) begin
                    e_err = 1; e_busy = 0; m_mode = 0;
                end else begin
                    e_busy = 1;
                    if (act) begin
                        e_we = 1;
                        e_addr = (int'(v_in) - VS) * W + (int'(h_in) - HS);
                        e_data = {r_in, g_in, b_in};
                        if (h_in == HE && v_in == VE) m_mode = 3;
                    end
                end
            end else begin
                e_fd = 1; e_busy = 0;
                m_mode = (cont_in || req_in) ? 1 : 0;
            end
            m_prev = cur;
        end
    endtask

    task automatic set_inputs();
        h_in = 16'(pos % HT);
        v_in = 16'(pos / HT);
        if (fix_col) {r_in, g_in, b_in} = 12'hA53;
        else {r_in, g_in, b_in} = 12'($urandom);
    endtask

    task automatic step();
        int nxt;
        @(posedge clk);
        model_update();
        #1;
        chk("write_en", 32'(write_en), 32'(e_we));
        chk("address", 32'(address_write), 32'(e_addr));
        chk("data", 32'(data_write), 32'(e_data));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        chk("capture_error", 32'(capture_error), 32'(e_err));
        if (write_en) begin
            if (!got_first) first_addr = int'(address_write);
            got_first = 1;
            last_addr = int'(address_write);
            nwr++;
        end
        if (frame_done) nfd++;
        if (capture_error) nerr++;
        nxt = pos + 1;
        if (pos == glitch_pos) begin
            nxt = pos + 2;
            glitch_pos = -1;
        end else if (glitch_rate != 0 && $urandom_range(glitch_rate - 1) == 0) begin
            nxt = pos + 1 + int'($urandom_range(1, 3));
        end
        pos = nxt % TOT;
        set_inputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_mon();
        nwr = 0; nfd = 0; nerr = 0; first_addr = -1; last_addr = -1; got_first = 0;
    endtask

    task automatic align_to(input int p);
        for (int i = 0; i < 2 * TOT && pos != p; i++) step();
        chk("align", 32'(pos), 32'(p));
    endtask

    task automatic pulse_req();
        req_in = 1; step(); req_in = 0;
    endtask

    initial begin
        rst_in = 0; req_in = 0; cont_in = 0;
        set_inputs();
        clear_mon();

        // reset, then a single capture requested at the top of a frame
        run(2);
        chk("rst_we", 32'(write_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_addr", 32'(address_write), 0);
        rst_in = 1;
        align_to(0);
        clear_mon();
        pulse_req();
        run(480);
        chk("single_writes", nwr, NPX);
        chk("single_done", nfd, 1);
        chk("single_first", first_addr, 0);
        chk("single_last", last_addr, NPX - 1);
        chk("single_busy", 32'(busy), 0);

        // request arriving in the middle of a frame
        align_to(5 * HT + 9);
        clear_mon();
        pulse_req();
        run(480);
        chk("mid_writes", nwr, NPX);
        chk("mid_done", nfd, 1);
        chk("mid_first", first_addr, 0);

        // constant colour: data holds outside the visible area
        fix_col = 1;
        set_inputs();
        align_to(0);
        clear_mon();
        pulse_req();
        run(480);
        chk("colour_writes", nwr, NPX);
        chk("colour_hold", 32'(data_write), 32'h0A53);
        fix_col = 0;

        // counter discontinuity on line VS+3, then a clean restart
        align_to(0);
        clear_mon();
        glitch_pos = (VS + 3) * HT + 8;
        pulse_req();
        run(480);
        chk("abort_err", nerr, 1);
        chk("abort_done", nfd, 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_partial", 32'(nwr < NPX), 1);
        align_to(0);
        clear_mon();
        pulse_req();
        run(480);
        chk("restart_writes", nwr, NPX);
        chk("restart_first", first_addr, 0);
        chk("restart_done", nfd, 1);

        // continuous mode: two back-to-back frames from one request
        align_to(0);
        clear_mon();
        cont_in = 1;
        pulse_req();
        run(440);
        cont_in = 0;
        chk("cont_done", nfd, 2);
        chk("cont_writes", nwr, 2 * NPX);
        rst_in = 0; step(); rst_in = 1;

        // reset in the middle of a capture
        align_to(0);
        clear_mon();
        pulse_req();
        for (int i = 0; i < 600 && nwr < 30; i++) step();
        chk("reset_wait", 32'(nwr >= 30), 1);
        rst_in = 0; step(); rst_in = 1;
        chk("rmid_we", 32'(write_en), 0);
        chk("rmid_busy", 32'(busy), 0);
        chk("rmid_addr", 32'(address_write), 0);
        chk("rmid_data", 32'(data_write), 0);
        clear_mon();
        pulse_req();
        run(480);
        chk("rmid_writes", nwr, NPX);
        chk("rmid_first", first_addr, 0);
        chk("rmid_done", nfd, 1);
        chk("rmid_err", nerr, 0);

        // random soak: requests, mode changes, counter glitches and resets
        glitch_rate = 400;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) cont_in = 1'($urandom_range(1));
            req_in = ($urandom_range(39) == 0);
            rst_in = ($urandom_range(799) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
